filter_decim_fifo: RTL and testbench

- Downstream stage of the FIR filter host. Consumes the signed filtered sample stream (filtered_out / output_valid) and decimates it by averaging groups of DECIM samples.
- Decimated results are buffered in a small synchronous FIFO. They are presented to the next consumer over a valid/ready handshake, with overflow detection and a synchronous flush.

---
 rtl/filter_decim_pkg.sv | 20 ++
 rtl/filter_decim_fifo_if.sv | 24 ++
 rtl/filter_sync_fifo.sv | 63 ++++++
 rtl/filter_decim_fifo.sv | 51 +++++
 tb/tb_filter_decim_fifo.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/filter_decim_pkg.sv
// filter_decim_pkg: shared widths, limits and sizing helpers for the decimating FIFO stage.
package filter_decim_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DECIM = 2;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int ACC_W = DEF_DATA_WIDTH + $clog2(DEF_DECIM);
   localparam int SHIFT = $clog2(DEF_DECIM);
   localparam int CNT_W = $clog2(DEF_FIFO_DEPTH + 1);
   localparam logic [7:0] DROP_MAX = 8'hFF;
   function automatic int shift_of(input int decim);
      return $clog2(decim);
   endfunction
   // DECIM=1 still needs a one-bit phase register
   function automatic int phase_w(input int decim);
      return decim > 1 ? $clog2(decim) : 1;
   endfunction
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/filter_decim_fifo_if.sv
// filter_decim_fifo_if: sample input, control and buffered output handshake of the decimator.
interface filter_decim_fifo_if import filter_decim_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
   logic signed [DATA_WIDTH-1:0] sample_in;
   logic                         sample_valid;
   logic                         flush;
   logic                         clr_ovf;
   logic signed [DATA_WIDTH-1:0] out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic [cnt_w(FIFO_DEPTH)-1:0] fifo_count;
   logic                         overflow;
   logic [7:0]                   drop_count;
   modport master (
      output sample_in, sample_valid, flush, clr_ovf, out_ready,
      input  out_data, out_valid, fifo_count, overflow, drop_count
   );
   modport slave (
      input  sample_in, sample_valid, flush, clr_ovf, out_ready,
      output out_data, out_valid, fifo_count, overflow, drop_count
   );
endinterface

// File: rtl/filter_sync_fifo.sv
// filter_sync_fifo: first-word-fall-through FIFO with wrap-bit pointers, sticky overflow
// and a saturating drop counter.
module filter_sync_fifo import filter_decim_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   input  logic                         flush,
   input  logic                         clr_ovf,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [WIDTH-1:0]             head_data,
   output logic                         overflow,
   output logic [7:0]                   drop_count
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]      r_wr, r_rd;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             r_ovf;
   logic [7:0]       r_drops;
   logic             w_pop, w_wr, w_drop;
   assign full       = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign empty      = r_wr == r_rd;
   assign w_pop      = pop && !empty && !flush;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign w_wr       = push && !flush && (!full || w_pop);
   assign w_drop     = push && !flush && full && !w_pop;
   assign count      = r_wr - r_rd;
   assign head_data  = empty ? '0 : r_mem[r_rd[AW-1:0]];
   assign overflow   = r_ovf;
   assign drop_count = r_drops;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_ovf   <= 1'b0;
         r_drops <= '0;
      end else begin
         if (flush) begin
            r_wr <= '0;
            r_rd <= '0;
         end else begin
            if (w_wr) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop) r_rd <= r_rd + (AW+1)'(1);
         end
         if (w_drop) begin
            r_ovf   <= 1'b1;
            r_drops <= clr_ovf ? 8'd1 : (r_drops == DROP_MAX ? DROP_MAX : r_drops + 8'd1);
         end else if (clr_ovf) begin
            r_ovf   <= 1'b0;
            r_drops <= '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/filter_decim_fifo.sv
// filter_decim_fifo: averages groups of DECIM signed samples (floor division) and
// queues the results for a valid/ready consumer.
module filter_decim_fifo import filter_decim_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DECIM      = DEF_DECIM,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input logic                 clk,
   input logic                 rst,
   filter_decim_fifo_if.slave  bus
);
   localparam int SH  = shift_of(DECIM);
   localparam int A_W = DATA_WIDTH + SH;
   localparam int P_W = phase_w(DECIM);
   logic signed [A_W-1:0]  r_acc, w_sum;
   logic [P_W-1:0]         r_ph;
   logic [DATA_WIDTH-1:0]  w_res;
   logic                   w_last, w_push, w_empty;
   assign w_last = r_ph == P_W'(DECIM - 1);
   assign w_sum  = r_acc + A_W'(bus.sample_in);
   assign w_res  = DATA_WIDTH'(w_sum >>> SH);
   assign w_push = bus.sample_valid && w_last && !bus.flush;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc <= '0;
         r_ph  <= '0;
      end else if (bus.flush) begin
         r_acc <= '0;
         r_ph  <= '0;
      end else if (bus.sample_valid) begin
         r_acc <= w_last ? '0 : w_sum;
         r_ph  <= w_last ? '0 : r_ph + P_W'(1);
      end
   end
   filter_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (w_push),
      .push_data  (w_res),
      .pop        (bus.out_ready),
      .flush      (bus.flush),
      .clr_ovf    (bus.clr_ovf),
      .full       (),
      .empty      (w_empty),
      .count      (bus.fifo_count),
      .head_data  (bus.out_data),
      .overflow   (bus.overflow),
      .drop_count (bus.drop_count)
   );
   assign bus.out_valid = !w_empty;
endmodule

// File: tb/tb_filter_decim_fifo.sv
// tb_filter_decim_fifo: scoreboard bench driving DECIM=1/2/4 instances through one selected port.
module tb_filter_decim_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic signed [7:0] s_in = '0;
   logic s_val = 1'b0, s_flush = 1'b0, s_clr = 1'b0, s_rdy = 1'b0;
   int sel = 1;
   filter_decim_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) b1 ();
   filter_decim_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) b2 ();
   filter_decim_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) b4 ();
   filter_decim_fifo #(.DATA_WIDTH(8), .DECIM(1), .FIFO_DEPTH(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
   filter_decim_fifo #(.DATA_WIDTH(8), .DECIM(2), .FIFO_DEPTH(8)) u2 (.clk(clk), .rst(rst), .bus(b2));
   filter_decim_fifo #(.DATA_WIDTH(8), .DECIM(4), .FIFO_DEPTH(8)) u4 (.clk(clk), .rst(rst), .bus(b4));
   assign b1.sample_in = s_in;
   assign b2.sample_in = s_in;
   assign b4.sample_in = s_in;
   assign b1.sample_valid = s_val && sel == 0;
   assign b2.sample_valid = s_val && sel == 1;
   assign b4.sample_valid = s_val && sel == 2;
   assign b1.flush = s_flush && sel == 0;
   assign b2.flush = s_flush && sel == 1;
   assign b4.flush = s_flush && sel == 2;
   assign b1.clr_ovf = s_clr && sel == 0;
   assign b2.clr_ovf = s_clr && sel == 1;
   assign b4.clr_ovf = s_clr && sel == 2;
   assign b1.out_ready = s_rdy && sel == 0;
   assign b2.out_ready = s_rdy && sel == 1;
   assign b4.out_ready = s_rdy && sel == 2;
   logic signed [7:0] m_data;
   logic [3:0] m_cnt;
   logic [7:0] m_drops;
   logic m_valid, m_ovf;
   always_comb begin
      m_data  = sel == 0 ? b1.out_data   : sel == 1 ? b2.out_data   : b4.out_data;
      m_valid = sel == 0 ? b1.out_valid  : sel == 1 ? b2.out_valid  : b4.out_valid;
      m_cnt   = sel == 0 ? b1.fifo_count : sel == 1 ? b2.fifo_count : b4.fifo_count;
      m_ovf   = sel == 0 ? b1.overflow   : sel == 1 ? b2.overflow   : b4.overflow;
      m_drops = sel == 0 ? b1.drop_count : sel == 1 ? b2.drop_count : b4.drop_count;
   end
   int q[$];
   int msum = 0, mph = 0, movf = 0, mdrop = 0, dec = 2;
   int n_chk = 0, n_pass = 0;
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask
   function automatic int fdiv(input int s, input int d);
      int r;
      r = s % d;
      if (r < 0) r += d;
      return (s - r) / d;
   endfunction
   task automatic do_reset();
      s_val = 1'b0; s_flush = 1'b0; s_clr = 1'b0; s_rdy = 1'b0;
      #3 rst = 1'b0;
      #1;
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_count", int'(m_cnt), 0);
      chk("rst_ovf", int'(m_ovf), 0);
      chk("rst_drops", int'(m_drops), 0);
      q.delete();
      msum = 0; mph = 0; movf = 0; mdrop = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask
   task automatic pick(input int s);
      sel = s;
      dec = s == 0 ? 1 : s == 1 ? 2 : 4;
      do_reset();
   endtask
   // drive one cycle: check outputs at the falling edge, then advance the model at the rising edge
   task automatic step(input logic v, input int d, input logic rd, input logic fl = 1'b0, input logic cl = 1'b0);
      int res;
      bit push, pop, drop;
      s_val = v; s_in = 8'(d); s_rdy = rd; s_flush = fl; s_clr = cl;
      @(negedge clk);
      chk("valid", int'(m_valid), int'(q.size() != 0));
      chk("count", int'(m_cnt), q.size());
      chk("overflow", int'(m_ovf), movf);
      chk("drops", int'(m_drops), mdrop);
      if (m_valid && rd && q.size() > 0) chk("data", int'(m_data), q[0]);
      @(posedge clk);
      push = 0; pop = 0; drop = 0; res = 0;
      if (fl) begin
         q.delete();
         msum = 0; mph = 0;
      end else begin
         pop = rd && q.size() > 0;
         if (v) begin
            msum += int'(s_in);
            mph++;
            if (mph == dec) begin
               push = 1;
               res = fdiv(msum, dec);
               msum = 0; mph = 0;
            end
         end
         drop = push && q.size() == 8 && !pop;
         if (pop) void'(q.pop_front());
         if (push && !drop) q.push_back(res);
      end
      if (drop) begin
         movf = 1;
         mdrop = cl ? 1 : (mdrop == 255 ? 255 : mdrop + 1);
      end else if (cl) begin
         movf = 0; mdrop = 0;
      end
      #1;
   endtask
   initial begin
      pick(1);
      step(1, 10, 0); step(1, 20, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 1);
      step(1, -3, 1); step(1, -4, 1); step(1, 127, 1); step(1, 127, 1);
      step(1, -128, 1); step(1, -128, 1);
      repeat (3) step(0, 0, 1);
      repeat (40) step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
      repeat (10) step(0, 0, 1);
      pick(0);
      for (int i = 1; i <= 9; i++) step(1, i, 0);
      step(0, 0, 0);
      repeat (9) step(0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0);
      for (int i = 20; i < 28; i++) step(1, i, 0);
      for (int i = 30; i < 34; i++) step(1, i, 1);
      repeat (10) step(0, 0, 1);
      for (int i = 40; i < 48; i++) step(1, i, 0);
      step(1, 50, 0); step(1, 51, 0); step(1, 52, 0, 0, 1); step(0, 0, 0, 0, 1);
      for (int i = 0; i < 260; i++) step(1, i, 0);
      step(0, 0, 0);
      step(0, 0, 0, 0, 1);
      repeat (10) step(0, 0, 1);
      pick(2);
      step(1, 100, 1); step(1, 100, 1); step(1, 100, 1);
      step(1, 77, 1, 1);
      step(1, 4, 1); step(1, 8, 1); step(1, 12, 1); step(1, 16, 1);
      repeat (3) step(0, 0, 1);
      for (int i = 0; i < 8; i++) step(1, i * 9 - 30, 0);
      step(1, 5, 1, 1);
      step(0, 0, 1);
      for (int i = 0; i < 8; i++) step(1, -i * 13, 1);
      repeat (4) step(0, 0, 1);
      pick(1);
      s_rdy = 1'b0;
      step(1, 1, 0); step(1, 3, 0); step(1, 5, 0); step(1, 7, 0); step(1, 9, 0); step(1, 11, 0);
      step(1, 100, 0);
      chk("pre_rst_count", int'(m_cnt), 3);
      do_reset();
      step(1, 6, 1); step(1, 8, 1);
      repeat (3) step(0, 0, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
